vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter_if.sv | 31 +++
 rtl/vram_arbiter.sv | 148 ++++++++++++++
 tb/tb_vram_arbiter.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vram_arbiter_if.sv
// Master-side bus bundle for vram_arbiter.
//   m_valid  : per-master request valid, held until the matching m_ready pulse
//   m_addr   : per-master word address, master i in slice i
//   m_wdata  : per-master write data
//   m_wstrb  : per-master byte strobes, all-zero means read
//   m_ready  : per-master one-cycle completion pulse (one-hot or zero)
//   m_rdata  : shared read data, valid while any m_ready bit is high
interface vram_arbiter_if #(
  parameter int unsigned AW  = 11,
  parameter int unsigned DW  = 32,
  parameter int unsigned NCH = 2
);
  localparam int unsigned NB = DW / 8;

  logic [NCH-1:0]    m_valid;
  logic [NCH*AW-1:0] m_addr;
  logic [NCH*DW-1:0] m_wdata;
  logic [NCH*NB-1:0] m_wstrb;
  logic [NCH-1:0]    m_ready;
  logic [DW-1:0]     m_rdata;

  modport master (
    output m_valid, m_addr, m_wdata, m_wstrb,
    input  m_ready, m_rdata
  );

  modport slave (
    input  m_valid, m_addr, m_wdata, m_wstrb,
    output m_ready, m_rdata
  );
endinterface

// File: rtl/vram_arbiter.sv
// Arbitrates NCH bus masters onto one synchronous single-port VRAM; the video
// fetch path has absolute priority and takes the RAM port whenever
// vid_active_i is high.
// Ports:
//   clk, resetn        : clock, asynchronous active-low reset
//   vid_active_i       : video fetch window (video owns the RAM while high)
//   vid_addr_i         : video word address
//   vid_rdata_o        : video read data (RAM output, one cycle after address)
//   mbus               : master bus bundle (vram_arbiter_if.slave)
//   mem_ce_o/we_o/addr_o/wdata_o : RAM control, byte-lane write enables
//   mem_rdata_i        : RAM read data, one cycle after ce
// Build option: define VRAM_ARB_RR_EN for round-robin grant; otherwise the
// lowest requesting master index wins.
module vram_arbiter #(
  parameter int unsigned AW  = 11,
  parameter int unsigned DW  = 32,
  parameter int unsigned NCH = 2
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            vid_active_i,
  input  logic [AW-1:0]   vid_addr_i,
  output logic [DW-1:0]   vid_rdata_o,
  vram_arbiter_if.slave   mbus,
  output logic            mem_ce_o,
  output logic [DW/8-1:0] mem_we_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [DW-1:0]   mem_wdata_o,
  input  logic [DW-1:0]   mem_rdata_i
);
  localparam int unsigned NB = DW / 8;
  localparam int unsigned GW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  logic [1:0]     state_q, state_d;
  logic [GW-1:0]  g_q, g_d;
  logic [NCH-1:0] ready_q, ready_d;
  logic [GW-1:0]  grant_c;

  // Per-master views of the flattened request buses
  logic [AW-1:0] addr_a  [NCH];
  logic [DW-1:0] wdata_a [NCH];
  logic [NB-1:0] wstrb_a [NCH];

  for (genvar i = 0; i < NCH; i++) begin : g_unpack
    assign addr_a[i]  = mbus.m_addr[i*AW +: AW];
    assign wdata_a[i] = mbus.m_wdata[i*DW +: DW];
    assign wstrb_a[i] = mbus.m_wstrb[i*NB +: NB];
  end

`ifdef VRAM_ARB_RR_EN
  logic [GW-1:0] ptr_q, ptr_d;
  logic          found;

  // Round-robin: first requester after the last granted index, wrapping
  always_comb begin
    grant_c = '0;
    found   = 1'b0;
    for (int unsigned k = 1; k <= NCH; k++) begin
      if (!found && mbus.m_valid[GW'((32'(ptr_q) + k) % NCH)]) begin
        grant_c = GW'((32'(ptr_q) + k) % NCH);
        found   = 1'b1;
      end
    end
  end
`else
  // Fixed priority: scan high to low so the lowest requester wins
  always_comb begin
    grant_c = '0;
    for (int i = int'(NCH) - 1; i >= 0; i--) begin
      if (mbus.m_valid[GW'(i)]) grant_c = GW'(i);
    end
  end
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    g_d     = g_q;
    ready_d = '0;
`ifdef VRAM_ARB_RR_EN
    ptr_d   = ptr_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if ((|mbus.m_valid) && !vid_active_i) begin
          g_d     = grant_c;
          state_d = ST_ISSUE;
`ifdef VRAM_ARB_RR_EN
          ptr_d   = grant_c;
`endif
        end
      end
      ST_ISSUE: begin
        // Video steals the port this cycle; retry until it lets go
        if (!vid_active_i) begin
          state_d      = ST_RESP;
          ready_d[g_q] = 1'b1;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      g_q     <= '0;
      ready_q <= '0;
`ifdef VRAM_ARB_RR_EN
      ptr_q   <= GW'(NCH - 1);
`endif
    end else begin
      state_q <= state_d;
      g_q     <= g_d;
      ready_q <= ready_d;
`ifdef VRAM_ARB_RR_EN
      ptr_q   <= ptr_d;
`endif
    end
  end

  // RAM port mux: video first, then the granted master during ISSUE.
  // Reset forces IDLE asynchronously, so no write enable can leak out.
  always_comb begin
    mem_ce_o    = 1'b0;
    mem_we_o    = '0;
    mem_addr_o  = addr_a[g_q];
    mem_wdata_o = wdata_a[g_q];
    if (vid_active_i) begin
      mem_ce_o   = 1'b1;
      mem_addr_o = vid_addr_i;
    end else if (state_q == ST_ISSUE) begin
      mem_ce_o = 1'b1;
      mem_we_o = wstrb_a[g_q];
    end
  end

  // RAM output in RESP still holds the ISSUE-cycle access
  assign mbus.m_ready = ready_q;
  assign mbus.m_rdata = mem_rdata_i;
  assign vid_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed testbench for vram_arbiter with a behavioural synchronous RAM.
module tb_vram_arbiter;
  localparam int unsigned AW  = 11;
  localparam int unsigned DW  = 32;
  localparam int unsigned NCH = 2;
  localparam int unsigned NB  = DW / 8;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          vid_active = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_rdata;
  logic          mem_ce;
  logic [NB-1:0] mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  vram_arbiter_if #(.AW(AW), .DW(DW), .NCH(NCH)) mbus ();

  vram_arbiter #(.AW(AW), .DW(DW), .NCH(NCH)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .vid_active_i (vid_active),
    .vid_addr_i   (vid_addr),
    .vid_rdata_o  (vid_rdata),
    .mbus         (mbus),
    .mem_ce_o     (mem_ce),
    .mem_we_o     (mem_we),
    .mem_addr_o   (mem_addr),
    .mem_wdata_o  (mem_wdata),
    .mem_rdata_i  (mem_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM with byte enables plus a preload port
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          bd_we = 1'b0;
  logic [AW-1:0] bd_addr = '0;
  logic [DW-1:0] bd_data = '0;

  always @(posedge clk) begin
    if (bd_we) ram[bd_addr] <= bd_data;
    if (mem_ce) begin
      for (int b = 0; b < int'(NB); b++)
        if (mem_we[b]) ram[mem_addr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bd_we = 1'b1; bd_addr = a; bd_data = d;
    tick();
    bd_we = 1'b0;
  endtask

  task automatic set_req(input int ch, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, input logic [NB-1:0] ws);
    mbus.m_addr[ch*AW +: AW]  = a;
    mbus.m_wdata[ch*DW +: DW] = wd;
    mbus.m_wstrb[ch*NB +: NB] = ws;
    mbus.m_valid[ch]          = 1'b1;
  endtask

  // One transaction; cyc counts the cycle the request was presented as 1
  task automatic txn(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                     input logic [NB-1:0] ws, output logic [DW-1:0] rd, output int cyc);
    set_req(ch, a, wd, ws);
    cyc = 1;
    rd  = '0;
    for (int k = 0; k < 50; k++) begin
      tick();
      cyc++;
      check("ready_onehot", 64'($onehot0(mbus.m_ready)), 64'(1));
      if (mbus.m_ready != '0) break;
    end
    check("ready_sel", 64'(mbus.m_ready), 64'(1) << ch);
    rd = mbus.m_rdata;
    mbus.m_valid[ch] = 1'b0;
    tick();
    check("ready_pulse", 64'(mbus.m_ready), 64'(0));
  endtask

  logic [DW-1:0] rd;
  int            cyc;
  logic [AW-1:0] vaddr [5];
  logic [DW-1:0] vexp  [5];
  int            grants [4];
  int            exp_g  [4];
  int            ng;

  initial begin
    mbus.m_valid = '0;
    mbus.m_addr  = '0;
    mbus.m_wdata = '0;
    mbus.m_wstrb = '0;

    // Reset state, with and without video
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(mbus.m_ready), 64'(0));
    check("rst_ce", 64'(mem_ce), 64'(0));
    check("rst_we", 64'(mem_we), 64'(0));
    vid_active = 1'b1; vid_addr = 11'h007;
    #1;
    check("rst_vid_ce", 64'(mem_ce), 64'(1));
    check("rst_vid_addr", 64'(mem_addr), 64'h007);
    check("rst_vid_we", 64'(mem_we), 64'(0));
    vid_active = 1'b0;
    resetn = 1'b1;
    tick();

    poke(11'h010, 32'hDEADBEEF);
    poke(11'h020, 32'h11223344);
    poke(11'h030, 32'hCAFEF00D);
    poke(11'h040, 32'h00000000);
    poke(11'h050, 32'hA5A5A5A5);
    tick();

    // Single read
    txn(0, 11'h010, '0, 4'b0000, rd, cyc);
    check("rd_lat", 64'(cyc), 64'(3));
    check("rd_data", 64'(rd), 64'hDEADBEEF);

    // Byte-strobe write then readback
    txn(1, 11'h020, 32'hAABBCCDD, 4'b0101, rd, cyc);
    check("bw_lat", 64'(cyc), 64'(3));
    txn(1, 11'h020, '0, 4'b0000, rd, cyc);
    check("bw_data", 64'(rd), 64'h11BB33DD);

    // Full write by master 0, read by master 1
    txn(0, 11'h040, 32'h12345678, 4'b1111, rd, cyc);
    txn(1, 11'h040, '0, 4'b0000, rd, cyc);
    check("fw_data", 64'(rd), 64'h12345678);

    // Video preempts an ISSUE for 5 cycles
    vaddr[0] = 11'h010; vaddr[1] = 11'h010; vaddr[2] = 11'h020;
    vaddr[3] = 11'h020; vaddr[4] = 11'h040;
    vexp[0] = 32'hDEADBEEF; vexp[1] = 32'hDEADBEEF; vexp[2] = 32'h11BB33DD;
    vexp[3] = 32'h11BB33DD; vexp[4] = 32'h12345678;
    set_req(0, 11'h050, 32'h55555555, 4'b1111);
    tick();
    for (int i = 0; i < 5; i++) begin
      vid_active = 1'b1;
      vid_addr   = vaddr[i];
      #1;
      check("vp_ce", 64'(mem_ce), 64'(1));
      check("vp_addr", 64'(mem_addr), 64'(vaddr[i]));
      check("vp_we", 64'(mem_we), 64'(0));
      tick();
      check("vp_noready", 64'(mbus.m_ready), 64'(0));
      check("vp_vrdata", 64'(vid_rdata), 64'(vexp[i]));
      check("vp_nowrite", 64'(ram[11'h050]), 64'hA5A5A5A5);
    end
    vid_active = 1'b0;
    cyc = 7;
    for (int k = 0; k < 20; k++) begin
      if (mbus.m_ready != '0) break;
      tick();
      cyc++;
    end
    check("vp_ready", 64'(mbus.m_ready), 64'(1));
    check("vp_lat", 64'(cyc), 64'(8));
    mbus.m_valid = '0;
    tick();
    check("vp_written", 64'(ram[11'h050]), 64'h55555555);

    // Video rising during RESP must not disturb read data
    set_req(0, 11'h040, '0, 4'b0000);
    tick();
    tick();
    check("rv_ready", 64'(mbus.m_ready), 64'(1));
    vid_active = 1'b1; vid_addr = 11'h010;
    #1;
    check("rv_rdata", 64'(mbus.m_rdata), 64'h12345678);
    mbus.m_valid = '0;
    tick();
    vid_active = 1'b0;
    check("rv_ready_off", 64'(mbus.m_ready), 64'(0));
    tick();

    // Contention after a fresh reset: both masters read continuously
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
`ifdef VRAM_ARB_RR_EN
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`else
    exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 0;
`endif
    set_req(0, 11'h010, '0, 4'b0000);
    set_req(1, 11'h020, '0, 4'b0000);
    ng = 0;
    for (int k = 0; k < 40 && ng < 4; k++) begin
      tick();
      if (mbus.m_ready != '0) begin
        check("ct_onehot", 64'($onehot(mbus.m_ready)), 64'(1));
        grants[ng] = mbus.m_ready[1] ? 1 : 0;
        check("ct_rdata", 64'(mbus.m_rdata),
              grants[ng] == 1 ? 64'h11BB33DD : 64'hDEADBEEF);
        ng++;
      end
    end
    mbus.m_valid = '0;
    check("ct_count", 64'(ng), 64'(4));
    for (int i = 0; i < ng; i++) check($sformatf("ct_grant%0d", i), 64'(grants[i]), 64'(exp_g[i]));
    repeat (3) tick();

    // Reset asserted during ISSUE of a write drops the access
    set_req(1, 11'h030, 32'hFFFFFFFF, 4'b1111);
    tick();
    check("ri_issue_we", 64'(mem_we), 64'hF);
    #1 resetn = 1'b0;
    #1;
    check("ri_we_sup", 64'(mem_we), 64'(0));
    mbus.m_valid = '0;
    repeat (2) tick();
    resetn = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      check("ri_noready", 64'(mbus.m_ready), 64'(0));
    end
    check("ri_unchanged", 64'(ram[11'h030]), 64'hCAFEF00D);
    txn(0, 11'h030, '0, 4'b0000, rd, cyc);
    check("ri_readback", 64'(rd), 64'hCAFEF00D);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

endmodule
